uart_program_loader: RTL and testbench

- Receives a byte stream from the MIPS UART receiver and recognises single-byte commands.
- A load command assembles the following bytes into NB_DATA-bit instruction words and writes them sequentially into instruction memory.
- Loading ends on a halt word. The block then returns an ACK or NACK byte through the UART transmitter.
- An execute command starts the processor. This block sits between uart_rx/uart_tx and the instruction memory/CPU start logic in top.

---
 rtl/loader_pkg.sv | 16 +
 rtl/loader_word_assembler.sv | 63 ++++++
 rtl/uart_program_loader.sv | 204 ++++++++++++++++++++
 tb/tb_uart_program_loader.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared types and byte codes for the UART program loader.
// The CHECK state only exists when PROGLOAD_CHECKSUM_EN is defined.
package loader_pkg;

`ifdef PROGLOAD_CHECKSUM_EN
   typedef enum logic [1:0] {StIdle, StLoad, StCheck, StReply} loader_state_e;
`else
   typedef enum logic [1:0] {StIdle, StLoad, StReply} loader_state_e;
`endif

   localparam logic [7:0] CMD_LOAD = 8'h4C;
   localparam logic [7:0] CMD_EXEC = 8'h45;
   localparam logic [7:0] RSP_ACK  = 8'h4B;
   localparam logic [7:0] RSP_NACK = 8'h4E;

endpackage

// File: rtl/loader_word_assembler.sv
// Packs a stream of bytes into words; the finished word sits in its own register so the
// shift register can keep accepting bytes while the word is being written out.
module loader_word_assembler #(
   parameter int unsigned NB_DATA    = 32,
   parameter int unsigned NB_BYTE    = 8,
   parameter bit          BIG_ENDIAN = 1'b1
) (
   input  logic               clock_i,
   input  logic               clear_i,
   input  logic [NB_BYTE-1:0] byte_i,
   input  logic               byte_valid_i,
   output logic [NB_DATA-1:0] word_o,
   output logic               word_valid_o
);

   localparam int unsigned NumBytes = NB_DATA / NB_BYTE;
   localparam int unsigned CntWidth = (NumBytes > 1) ? $clog2(NumBytes) : 1;
   localparam logic [CntWidth-1:0] LastByte = CntWidth'(NumBytes - 1);

   logic [CntWidth-1:0] cnt_q, cnt_d;
   logic [NB_DATA-1:0]  shift_q, shift_d;
   logic [NB_DATA-1:0]  word_q, word_d;
   logic                valid_q, valid_d;

   always_comb begin
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = 1'b0;
      if (byte_valid_i) begin
         if (BIG_ENDIAN) begin
            shift_d = (shift_q << NB_BYTE) | NB_DATA'(byte_i);
         end else begin
            shift_d = (shift_q >> NB_BYTE) | (NB_DATA'(byte_i) << (NB_DATA - NB_BYTE));
         end
         if (cnt_q == LastByte) begin
            cnt_d   = '0;
            word_d  = shift_d;
            valid_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clock_i) begin
      if (clear_i) begin
         cnt_q   <= '0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
      end
   end

   assign word_o       = word_q;
   assign word_valid_o = valid_q;

endmodule

// File: rtl/uart_program_loader.sv
// UART command front-end: 'L' streams words into instruction memory until the halt word,
// 'E' starts the CPU. Define PROGLOAD_CHECKSUM_EN to require a trailing XOR byte.
module uart_program_loader
   import loader_pkg::*;
#(
   parameter int unsigned        NB_DATA        = 32,
   parameter int unsigned        NB_BYTE        = 8,
   parameter int unsigned        NB_ADDR        = 10,
   parameter logic [NB_DATA-1:0] HALT_WORD      = 32'hF400_0000,
   parameter int unsigned        TIMEOUT_CYCLES = 1_000_000,
   parameter bit                 BIG_ENDIAN     = 1'b1
) (
   input  logic               i_clock,
   input  logic               i_reset,
   input  logic [NB_BYTE-1:0] i_rx_data,
   input  logic               i_rx_valid,
   input  logic               i_tx_busy,
   output logic [NB_BYTE-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_imem_wr_en,
   output logic [NB_ADDR-1:0] o_imem_addr,
   output logic [NB_DATA-1:0] o_imem_wr_data,
   output logic               o_program_loaded,
   output logic               o_exec_start,
   output logic               o_load_error,
   output logic [NB_ADDR:0]   o_word_count
);

   localparam int unsigned TmoWidth = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [NB_ADDR-1:0] AddrMax = '1;

   loader_state_e      state_q, state_d;
   logic [NB_ADDR-1:0] addr_q, addr_d;
   logic [NB_ADDR:0]   count_q, count_d;
   logic [TmoWidth-1:0] tmo_q, tmo_d;
   logic [NB_BYTE-1:0] tx_data_q, tx_data_d;
   logic               tx_start_q, tx_start_d;
   logic               loaded_q, loaded_d;
   logic               error_q, error_d;
   logic               exec_q, exec_d;
`ifdef PROGLOAD_CHECKSUM_EN
   logic [NB_BYTE-1:0] csum_q, csum_d;
`endif

   logic               cmd_load, cmd_exec, timeout, asm_clear, asm_strobe, word_valid;
   logic [NB_DATA-1:0] word;

   assign cmd_load = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_LOAD));
   assign cmd_exec = i_rx_valid && (i_rx_data == NB_BYTE'(CMD_EXEC));
`ifdef PROGLOAD_CHECKSUM_EN
   assign timeout = ((state_q == StLoad) || (state_q == StCheck)) && !i_rx_valid &&
                    (tmo_q == TmoWidth'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = (state_q == StLoad) && !i_rx_valid &&
                    (tmo_q == TmoWidth'(TIMEOUT_CYCLES - 1));
`endif
   // A timeout also flushes any partially assembled word.
   assign asm_clear  = !i_reset || ((state_q == StIdle) && cmd_load) || timeout;
   assign asm_strobe = i_rx_valid && (state_q == StLoad);

   loader_word_assembler #(
      .NB_DATA   (NB_DATA),
      .NB_BYTE   (NB_BYTE),
      .BIG_ENDIAN(BIG_ENDIAN)
   ) u_assembler (
      .clock_i     (i_clock),
      .clear_i     (asm_clear),
      .byte_i      (i_rx_data),
      .byte_valid_i(asm_strobe),
      .word_o      (word),
      .word_valid_o(word_valid)
   );

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      count_d    = count_q;
      tmo_d      = '0;
      tx_data_d  = tx_data_q;
      tx_start_d = 1'b0;
      loaded_d   = loaded_q;
      error_d    = error_q;
      exec_d     = 1'b0;
`ifdef PROGLOAD_CHECKSUM_EN
      csum_d     = csum_q;
`endif
      unique case (state_q)
         StIdle: begin
            if (cmd_load) begin
               state_d  = StLoad;
               addr_d   = '0;
               count_d  = '0;
               loaded_d = 1'b0;
               error_d  = 1'b0;
`ifdef PROGLOAD_CHECKSUM_EN
               csum_d   = '0;
`endif
            end else if (cmd_exec) begin
               if (loaded_q) begin
                  exec_d = 1'b1;
               end else begin
                  state_d   = StReply;
                  tx_data_d = NB_BYTE'(RSP_NACK);
               end
            end
         end
         StLoad: begin
            tmo_d = i_rx_valid ? '0 : tmo_q + 1'b1;
`ifdef PROGLOAD_CHECKSUM_EN
            if (i_rx_valid) csum_d = csum_q ^ i_rx_data;
`endif
            if (timeout) begin
               error_d   = 1'b1;
               state_d   = StReply;
               tx_data_d = NB_BYTE'(RSP_NACK);
            end else if (word_valid) begin
               addr_d  = addr_q + 1'b1;
               count_d = count_q + 1'b1;
               if (word == HALT_WORD) begin
`ifdef PROGLOAD_CHECKSUM_EN
                  state_d   = StCheck;
`else
                  state_d   = StReply;
                  tx_data_d = NB_BYTE'(RSP_ACK);
                  loaded_d  = 1'b1;
`endif
               end else if (addr_q == AddrMax) begin
                  error_d   = 1'b1;
                  state_d   = StReply;
                  tx_data_d = NB_BYTE'(RSP_NACK);
               end
            end
         end
`ifdef PROGLOAD_CHECKSUM_EN
         StCheck: begin
            tmo_d = tmo_q + 1'b1;
            if (i_rx_valid) begin
               state_d = StReply;
               if (i_rx_data == csum_q) begin
                  tx_data_d = NB_BYTE'(RSP_ACK);
                  loaded_d  = 1'b1;
               end else begin
                  tx_data_d = NB_BYTE'(RSP_NACK);
                  error_d   = 1'b1;
                  loaded_d  = 1'b0;
               end
            end else if (timeout) begin
               error_d   = 1'b1;
               state_d   = StReply;
               tx_data_d = NB_BYTE'(RSP_NACK);
            end
         end
`endif
         StReply: begin
            if (!i_tx_busy) begin
               tx_start_d = 1'b1;
               state_d    = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (!i_reset) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         count_q    <= '0;
         tmo_q      <= '0;
         tx_data_q  <= '0;
         tx_start_q <= 1'b0;
         loaded_q   <= 1'b0;
         error_q    <= 1'b0;
         exec_q     <= 1'b0;
`ifdef PROGLOAD_CHECKSUM_EN
         csum_q     <= '0;
`endif
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         count_q    <= count_d;
         tmo_q      <= tmo_d;
         tx_data_q  <= tx_data_d;
         tx_start_q <= tx_start_d;
         loaded_q   <= loaded_d;
         error_q    <= error_d;
         exec_q     <= exec_d;
`ifdef PROGLOAD_CHECKSUM_EN
         csum_q     <= csum_d;
`endif
      end
   end

   assign o_tx_data        = tx_data_q;
   assign o_tx_start       = tx_start_q;
   assign o_imem_wr_en     = word_valid;
   assign o_imem_addr      = addr_q;
   assign o_imem_wr_data   = word;
   assign o_program_loaded = loaded_q;
   assign o_exec_start     = exec_q;
   assign o_load_error     = error_q;
   assign o_word_count     = count_q;

endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized self-checking bench for uart_program_loader; expected writes and replies come
// from the word list of each program. Honours PROGLOAD_CHECKSUM_EN when defined.
module tb_uart_program_loader;
   import loader_pkg::*;

   localparam int unsigned NB_ADDR = 5;
   localparam int unsigned DEPTH   = 1 << NB_ADDR;
   localparam int unsigned TMO     = 100;
   localparam logic [31:0] HALT    = 32'hF400_0000;
`ifdef PROGLOAD_CHECKSUM_EN
   localparam bit CK_EN = 1'b1;
`else
   localparam bit CK_EN = 1'b0;
`endif

   logic               clock = 1'b0;
   logic               reset = 1'b0;
   logic [7:0]         rx_data = 8'h00;
   logic               rx_valid = 1'b0;
   logic               tx_busy = 1'b0;
   logic [7:0]         tx_data;
   logic               tx_start, wr_en, loaded, exec_start, load_error;
   logic [NB_ADDR-1:0] wr_addr;
   logic [31:0]        wr_data;
   logic [NB_ADDR:0]   word_count;

   always #5 clock = ~clock;

   uart_program_loader #(
      .NB_ADDR       (NB_ADDR),
      .TIMEOUT_CYCLES(TMO)
   ) dut (
      .i_clock         (clock),
      .i_reset         (reset),
      .i_rx_data       (rx_data),
      .i_rx_valid      (rx_valid),
      .i_tx_busy       (tx_busy),
      .o_tx_data       (tx_data),
      .o_tx_start      (tx_start),
      .o_imem_wr_en    (wr_en),
      .o_imem_addr     (wr_addr),
      .o_imem_wr_data  (wr_data),
      .o_program_loaded(loaded),
      .o_exec_start    (exec_start),
      .o_load_error    (load_error),
      .o_word_count    (word_count)
   );

   int n_checks = 0;
   int n_fail = 0;
   int cyc = 0;
   int tx_cyc = 0;
   int exec_cnt = 0;
   logic [NB_ADDR-1:0] wr_addr_q[$];
   logic [31:0]        wr_data_q[$];
   logic [7:0]         tx_q[$];

   always @(posedge clock) cyc <= cyc + 1;

   // Observed traffic is only appended; each scenario records where its part begins.
   always @(negedge clock) begin
      if (wr_en) begin
         wr_addr_q.push_back(wr_addr);
         wr_data_q.push_back(wr_data);
      end
      if (tx_start) begin
         tx_q.push_back(tx_data);
         tx_cyc <= cyc;
      end
      if (exec_start) exec_cnt <= exec_cnt + 1;
   end

   task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rand_word();
      logic [31:0] w;
      w = $urandom;
      if (w == HALT) w = 32'h0;
      return w;
   endfunction

   // Called on a negedge; returns on a negedge after 0..2 idle cycles.
   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clock);
   endtask

   logic [31:0] prog[$];
   int          exp_n, base_wr, base_tx, base_exec;
   logic [7:0]  exp_rsp;

   task automatic send_prog(input bit bad_ck);
      logic [7:0] ck;
      bit halted, ovf;
      exp_n = 0; halted = 0; ovf = 0; ck = 8'h00;
      base_wr = wr_addr_q.size();
      base_tx = tx_q.size();
      send_byte(CMD_LOAD);
      while (exp_n < prog.size() && !halted && !ovf) begin
         for (int k = 3; k >= 0; k--) begin
            ck ^= prog[exp_n][8*k +: 8];
            send_byte(prog[exp_n][8*k +: 8]);
         end
         if (prog[exp_n] == HALT) halted = 1;
         else if (exp_n == DEPTH - 1) ovf = 1;
         exp_n++;
      end
      exp_rsp = halted ? RSP_ACK : RSP_NACK;
      if (CK_EN && halted) begin
         repeat (2) @(negedge clock);
         send_byte(bad_ck ? ~ck : ck);
         if (bad_ck) exp_rsp = RSP_NACK;
      end
   endtask

   task automatic wait_reply(input string tag, input logic [7:0] exp);
      int t;
      t = 0;
      while (tx_q.size() == base_tx && t < 3000) begin
         @(negedge clock);
         t++;
      end
      repeat (3) @(negedge clock);
      check_value({tag, "_ntx"}, tx_q.size() - base_tx, 1);
      if (tx_q.size() > base_tx) check_value({tag, "_tx"}, tx_q[base_tx], exp);
   endtask

   task automatic check_load(input string tag);
      wait_reply(tag, exp_rsp);
      check_value({tag, "_nwr"}, wr_addr_q.size() - base_wr, exp_n);
      for (int i = 0; i < exp_n && base_wr + i < wr_addr_q.size(); i++) begin
         check_value({tag, "_addr"}, wr_addr_q[base_wr+i], i);
         check_value({tag, "_data"}, wr_data_q[base_wr+i], prog[i]);
      end
      check_value({tag, "_loaded"}, loaded, exp_rsp == RSP_ACK);
      check_value({tag, "_error"}, load_error, exp_rsp != RSP_ACK);
      check_value({tag, "_count"}, word_count, exp_n);
   endtask

   task automatic check_idle_outputs(input string tag);
      check_value({tag, "_txd"}, tx_data, 0);
      check_value({tag, "_txs"}, tx_start, 0);
      check_value({tag, "_wren"}, wr_en, 0);
      check_value({tag, "_addr"}, wr_addr, 0);
      check_value({tag, "_wdata"}, wr_data, 0);
      check_value({tag, "_loaded"}, loaded, 0);
      check_value({tag, "_exec"}, exec_start, 0);
      check_value({tag, "_err"}, load_error, 0);
      check_value({tag, "_count"}, word_count, 0);
   endtask

   initial begin
      int t0;
      repeat (3) @(negedge clock);
      check_idle_outputs("reset");
      reset = 1'b1;
      @(negedge clock);

      // Execute with nothing loaded.
      base_tx = tx_q.size();
      base_exec = exec_cnt;
      send_byte(CMD_EXEC);
      wait_reply("exec_cold", RSP_NACK);
      check_value("exec_cold_pulse", exec_cnt - base_exec, 0);

      // Standard 18-word program containing command-looking data bytes.
      prog = {};
      prog.push_back(32'h2001_0005);
      prog.push_back(32'h454C_0045);
      for (int i = 0; i < 14; i++) prog.push_back(rand_word());
      prog.push_back(32'h4000_0000);
      prog.push_back(HALT);
      send_prog(1'b0);
      check_load("std");

      base_tx = tx_q.size();
      base_exec = exec_cnt;
      send_byte(CMD_EXEC);
      repeat (5) @(negedge clock);
      check_value("exec_pulse", exec_cnt - base_exec, 1);
      check_value("exec_no_tx", tx_q.size() - base_tx, 0);

      for (int r = 0; r < 4; r++) begin
         prog = {};
         for (int i = 0; i < int'($urandom_range(0, 12)); i++) prog.push_back(rand_word());
         prog.push_back(HALT);
         send_prog(1'b0);
         check_load("rand");
      end

      // Reply held off by a busy transmitter.
      prog = {rand_word(), rand_word(), rand_word(), HALT};
      tx_busy = 1'b1;
      send_prog(1'b0);
      repeat (50) @(negedge clock);
      check_value("busy_hold", tx_q.size() - base_tx, 0);
      tx_busy = 1'b0;
      check_load("busy");

      // Overflow: more non-halt words than memory holds.
      prog = {};
      for (int i = 0; i < int'(DEPTH) + 2; i++) prog.push_back(rand_word());
      send_prog(1'b0);
      check_load("ovf");

      // Timeout after a partial word.
      base_wr = wr_addr_q.size();
      base_tx = tx_q.size();
      send_byte(CMD_LOAD);
      send_byte(8'h11);
      send_byte(8'h22);
      rx_data = 8'h33;
      rx_valid = 1'b1;
      @(negedge clock);
      rx_valid = 1'b0;
      t0 = cyc;
      wait_reply("tmo", RSP_NACK);
      check_value("tmo_latency", (tx_cyc - t0 >= 95) && (tx_cyc - t0 <= 110), 1);
      check_value("tmo_nwr", wr_addr_q.size() - base_wr, 0);
      check_value("tmo_error", load_error, 1);
      check_value("tmo_loaded", loaded, 0);

      // Reset in the middle of a load, then a clean reload.
      prog = {rand_word(), rand_word(), rand_word(), HALT};
      send_byte(CMD_LOAD);
      for (int w = 0; w < 2; w++)
         for (int k = 3; k >= 0; k--) send_byte(prog[w][8*k +: 8]);
      repeat (2) @(negedge clock);
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_idle_outputs("midrst");
      reset = 1'b1;
      @(negedge clock);
      prog = {};
      for (int i = 0; i < 5; i++) prog.push_back(rand_word());
      prog.push_back(HALT);
      send_prog(1'b0);
      check_load("reload");

`ifdef PROGLOAD_CHECKSUM_EN
      prog = {rand_word(), rand_word(), rand_word(), rand_word(), HALT};
      send_prog(1'b0);
      check_load("ck_good");
      send_prog(1'b1);
      check_load("ck_bad");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
